// File: rtl/pdm_capture_ctrl.sv
// Capture sequencer between the PDM CIC output and the CPU: gates the mic clock,
// drops settling samples, buffers PCM words in a first-word-fall-through FIFO.
module pdm_capture_ctrl #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stop,
  input  logic [7:0]    settle_count,
  input  logic [15:0]   sample_count,
  input  logic [AW:0]   threshold,
  input  logic          irq_en,
  input  logic          clr_flags,
  input  logic [15:0]   pcm_in,
  input  logic          pcm_valid,
  input  logic          rd_en,
  output logic [15:0]   rd_data,
  output logic [AW:0]   level,
  output logic          empty,
  output logic          full,
  output logic          mic_clk_en,
  output logic          busy,
  output logic          overflow,
  output logic          done,
  output logic          irq
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t       state_reg, state_next;
  logic         mic_clk_en_reg, mic_clk_en_next;
  logic [7:0]   settle_lat_reg;
  logic [15:0]  sample_lat_reg;
  logic [7:0]   settle_cnt_reg;
  logic [15:0]  sample_cnt_reg;
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]  level_reg;
  logic         overflow_reg, done_reg, irq_reg;
  logic [15:0]  mem [DEPTH];

  logic         start_go;
  logic         settle_strobe, settle_hit;
  logic         cap_strobe, count_hit;
  logic         push, pop, drop;
  logic [7:0]   settle_inc;
  logic [15:0]  sample_inc;

  // stop dominates start; a start also suppresses any same-cycle push/pop.
  assign start_go      = start & ~stop;
  assign settle_inc    = settle_cnt_reg + 8'd1;
  assign sample_inc    = sample_cnt_reg + 16'd1;
  assign settle_strobe = (state_reg == SETTLE) & pcm_valid & ~start & ~stop;
  assign settle_hit    = settle_strobe & (settle_inc == settle_lat_reg);
  assign cap_strobe    = (state_reg == CAPTURE) & pcm_valid & ~start & ~stop;
  assign count_hit     = cap_strobe & (sample_lat_reg != 16'd0) & (sample_inc == sample_lat_reg);

  assign empty = (level_reg == '0);
  assign full  = (level_reg == (AW+1)'(DEPTH));
  assign pop   = rd_en & ~empty & ~start_go;
  assign push  = cap_strobe & (~full | pop);
  assign drop  = cap_strobe & ~push;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      mic_clk_en_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      mic_clk_en_reg <= mic_clk_en_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    if (stop) begin
      state_next = IDLE;
    end else if (start) begin
      state_next = (settle_count != 8'd0) ? SETTLE : CAPTURE;
    end else begin
      case (state_reg)
        SETTLE:  if (settle_hit) state_next = CAPTURE;
        CAPTURE: if (count_hit)  state_next = IDLE;
        default: state_next = state_reg;
      endcase
    end
  end

  // Output logic
  always_comb begin
    busy            = (state_reg != IDLE);
    mic_clk_en_next = (state_next != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      settle_lat_reg <= '0;
      sample_lat_reg <= '0;
      settle_cnt_reg <= '0;
      sample_cnt_reg <= '0;
    end else if (start_go) begin
      settle_lat_reg <= settle_count;
      sample_lat_reg <= sample_count;
      settle_cnt_reg <= '0;
      sample_cnt_reg <= '0;
    end else begin
      if (settle_strobe) settle_cnt_reg <= settle_inc;
      if (cap_strobe)    sample_cnt_reg <= sample_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else if (start_go) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      level_reg <= level_reg + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= pcm_in;
  end

  // Flag set events take priority over clr_flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow_reg <= 1'b0;
      done_reg     <= 1'b0;
    end else if (start_go) begin
      overflow_reg <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      if (drop)           overflow_reg <= 1'b1;
      else if (clr_flags) overflow_reg <= 1'b0;
      if (count_hit)      done_reg <= 1'b1;
      else if (clr_flags) done_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) irq_reg <= 1'b0;
    else        irq_reg <= irq_en & (((threshold != '0) & (level_reg >= threshold))
                                     | overflow_reg | done_reg);
  end

  assign rd_data    = empty ? 16'd0 : mem[rd_ptr_reg];
  assign level      = level_reg;
  assign mic_clk_en = mic_clk_en_reg;
  assign overflow   = overflow_reg;
  assign done       = done_reg;
  assign irq        = irq_reg;

endmodule

// File: doc/pdm_capture_ctrl.md
Name: pdm_capture_ctrl

Overview:
- Sequences PCM capture from the PDM microphone CIC datapath.
- On a CPU start it gates the mic clock on, discards startup samples, then buffers PCM words in a small FIFO for the CPU to read.
- Stops after a programmed sample count, or runs continuously.
- Raises an interrupt on FIFO threshold, completion or overflow; sits between the CIC output and the TinyQV register interface.

Parameters:
- DEPTH, 8: FIFO depth in 16-bit words; power of 2, minimum 2.
- AW, 3: log2(DEPTH).

Ports:
- clk  in  1  system clock (64 MHz).
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle pulse: begin a capture.
- stop  in  1  one-cycle pulse: abort capture.
- settle_count  in  8  PCM samples discarded after start.
- sample_count  in  16  samples to capture; 0 = continuous.
- threshold  in  AW+1  FIFO level interrupt threshold; 0 disables the level interrupt.
- irq_en  in  1  interrupt enable.
- clr_flags  in  1  pulse: clear the overflow and done flags.
- pcm_in  in  16  PCM sample from the CIC; already in the clk domain.
- pcm_valid  in  1  one-cycle strobe; pcm_in is valid this cycle.
- rd_en  in  1  pulse: pop the FIFO head.
- rd_data  out  16  FIFO head (first-word fall-through); 0 when empty.
- level  out  AW+1  FIFO occupancy, 0..DEPTH.
- empty  out  1  level == 0.
- full  out  1  level == DEPTH.
- mic_clk_en  out  1  gates the PDM clock to the microphone.
- busy  out  1  state != IDLE.
- overflow  out  1  sticky: a sample was dropped because the FIFO was full.
- done  out  1  sticky: the counted capture completed.
- irq  out  1  registered interrupt request.

Behaviour:

Reset:
- state = IDLE; FIFO pointers and level = 0.
- All counters 0; overflow, done, irq, mic_clk_en = 0.

States (2-bit):
- IDLE = 0, SETTLE = 1, CAPTURE = 2.

Outputs by state:
- mic_clk_en = 1 in SETTLE and CAPTURE, registered.
- busy = state != IDLE.

start (any state):
- Flushes the FIFO (level = 0) and clears overflow, done, the settle counter and the sample counter.
- Next state is SETTLE if settle_count != 0, else CAPTURE.
- settle_count and sample_count are latched at start; later changes do not affect a running capture.

stop:
- Next state is IDLE; FIFO contents and flags are kept.
- start and stop in the same cycle: stop wins, and the start side-effects (flush, flag clear) do not occur.

SETTLE:
- Each pcm_valid increments the settle counter; the sample is never written.
- When the counter reaches the latched settle_count, go to CAPTURE in the next cycle.
- The strobe that reaches the count is also discarded.

CAPTURE:
- On pcm_valid, if the FIFO is not full (after accounting for a same-cycle pop), write pcm_in at the write pointer. Otherwise drop the sample and set overflow.
- Every pcm_valid, written or dropped, increments the sample counter.
- If the latched sample_count != 0 and the incremented count equals it: go to IDLE and set done in the same edge. The final sample is still written if there is room.
- sample_count = 0: the counter wraps at 2^16 without effect.

FIFO:
- Pointers are AW bits and wrap modulo DEPTH.
- rd_data = mem[rd_ptr] when not empty.
- rd_en while empty is ignored; level never underflows.
- rd_en together with a push:
  - when full: both happen, level stays DEPTH, no overflow;
  - when empty: the push happens, the pop is ignored, level = 1.
- Written data is visible on rd_data the cycle after the write edge.

Flags:
- clr_flags clears overflow and done.
- If clr_flags coincides with a new overflow or done event, the set wins.
- pcm_valid in IDLE is ignored; no flag changes.

Interrupt:
- irq is registered: irq <= irq_en & ((threshold != 0 & level >= threshold) | overflow | done), using current-cycle register values.
- irq therefore lags its cause by one cycle.

Test Plan:
1. Reset, then settle_count=3, sample_count=4, DEPTH=8, start; pulse pcm_valid with pcm_in 0x0001..0x0007, spaced 4 cycles apart -> 0x0001–0x0003 discarded; FIFO holds 0x0004–0x0007 (level=4); done=1; state IDLE; mic_clk_en falls the cycle after the 7th strobe.
2. settle_count=0, sample_count=0, threshold=4, irq_en=1, start, 4 strobes -> irq rises 1 cycle after level reaches 4; reading 0x0001 drops level to 3 and irq clears 1 cycle later.
3. Continuous capture with no reads, 10 strobes -> level=8, full=1, overflow=1; rd_data = the first sample; samples 9–10 lost; irq set.
4. With the FIFO full, rd_en and pcm_valid in the same cycle -> level stays 8, overflow stays 0, new sample is last out; rd_en on empty -> level stays 0.
5. stop during SETTLE, and start during CAPTURE with level=5 -> stop: IDLE, mic_clk_en=0 next cycle. Start: level=0, overflow/done cleared, re-enter SETTLE. start+stop in the same cycle -> IDLE, FIFO kept.
6. Assert rst_n=0 mid-CAPTURE with level=3 and overflow=1 -> next edge: all outputs at reset values, rd_data=0.
